wb_retire_queue: RTL and testbench

- Parametrised successor to the combinational write-back select.
- Buffers decoded results in an in-order queue of DEPTH entries.
- Loads stall at the queue head until the data-memory response arrives; the response is then byte-lane aligned and extended for the load width.
- Drives a registered register-file write port and sits between execute/memory issue and the register file.

---
 rtl/cu_pkg.sv | 41 ++++
 rtl/wb_fifo.sv | 39 +++
 rtl/wb_retire_queue.sv | 82 ++++++++
 tb/tb_wb_retire_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: op codes, queue entry layout and write-back helpers shared by wb_retire_queue.
package cu_pkg;
  localparam int XLEN_MAX = 64;
  typedef enum logic [5:0] {
    CU_ERROR = 6'd0, CU_ADD, CU_ADDI, CU_SUB, CU_AND, CU_OR, CU_XOR, CU_SLL, CU_SRL, CU_SRA,
    CU_SLT, CU_SLTU, CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
    CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
    CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU, CU_LD, CU_LWU,
    CU_SB, CU_SH, CU_SW, CU_SD
  } cuOPType;
  // Fields are sized for the widest datapath; narrower builds zero-fill the top.
  typedef struct packed {
    cuOPType op;
    logic [4:0] rd;
    logic [XLEN_MAX-1:0] pc;
    logic [XLEN_MAX-1:0] alu;
    logic [XLEN_MAX-1:0] imm;
    logic [2:0] addr_lo;
  } wb_entry_t;
  function automatic logic is_load(cuOPType op);
    return op inside {CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU, CU_LD, CU_LWU};
  endfunction
  function automatic logic writes_rd(cuOPType op);
    return !(op inside {CU_ERROR, CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
                        CU_SB, CU_SH, CU_SW, CU_SD});
  endfunction
  function automatic logic [XLEN_MAX-1:0] load_extend(cuOPType op, logic [XLEN_MAX-1:0] rdata,
                                                      logic [2:0] addr_lo);
    logic [XLEN_MAX-1:0] sh;
    sh = rdata >> {addr_lo, 3'b000};
    case (op)
      CU_LB:   return {{56{sh[7]}}, sh[7:0]};
      CU_LH:   return {{48{sh[15]}}, sh[15:0]};
      CU_LW:   return {{32{sh[31]}}, sh[31:0]};
      CU_LBU:  return {56'b0, sh[7:0]};
      CU_LHU:  return {48'b0, sh[15:0]};
      CU_LWU:  return {32'b0, sh[31:0]};
      default: return sh;
    endcase
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of T entries with a combinational view of the head entry.
module wb_fifo #(
  parameter type T = logic [7:0],
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else begin
      rp <= rp + AW'(do_pop);
      wp <= wp + AW'(do_push);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/wb_retire_queue.sv
// wb_retire_queue: in-order write-back queue; loads wait at the head for memory data.
// WB_BYPASS_EN: a non-load arriving at an empty queue is written to the RF registers directly.
module wb_retire_queue
  import cu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                in_op,
  input  logic [4:0]                in_rd,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [XLEN-1:0]           in_alu,
  input  logic [XLEN-1:0]           in_imm,
  input  logic [$clog2(XLEN/8)-1:0] in_addr_lo,
  input  logic                      mem_rvalid,
  input  logic [XLEN-1:0]           mem_rdata,
  output logic                      rf_we,
  output logic [4:0]                rf_waddr,
  output logic [XLEN-1:0]           rf_wdata,
  output logic                      busy,
  output logic                      err_unexp_rsp
);
  wb_entry_t e_in, head, src;
  cuOPType op_in;
  logic full, empty, enq, byp, push, retire, do_wr, wr, armed;
  logic [XLEN_MAX-1:0] lui_v, res;
  // LD/LWU do not exist on a 32-bit datapath; they degrade to a silent error op.
  assign op_in = (XLEN == 32 && (cuOPType'(in_op) inside {CU_LD, CU_LWU})) ? CU_ERROR : cuOPType'(in_op);
  assign e_in = '{op: op_in, rd: in_rd, pc: 64'(in_pc), alu: 64'(in_alu), imm: 64'(in_imm),
                  addr_lo: 3'(in_addr_lo)};
  assign in_ready = !full;
  assign enq = in_valid & in_ready;
`ifdef WB_BYPASS_EN
  assign byp = enq & empty & !is_load(op_in);
`else
  assign byp = 1'b0;
`endif
  assign push = enq & !byp;
  assign retire = !empty & (!is_load(head.op) | mem_rvalid);
  assign do_wr = retire | byp;
  assign src = byp ? e_in : head;
  assign wr = do_wr & writes_rd(src.op) & (src.rd != 5'd0);
  assign lui_v = {{32{src.imm[31]}}, src.imm[31:12], 12'b0};
  assign res = is_load(src.op) ? load_extend(src.op, 64'(mem_rdata), src.addr_lo)
             : src.op == CU_LUI ? lui_v
             : src.op == CU_AUIPC ? src.pc + lui_v
             : (src.op == CU_JAL || src.op == CU_JALR) ? src.pc + 64'd4
             : src.alu;
  assign busy = !empty | rf_we;
  wb_fifo #(.T(wb_entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(e_in), .pop(retire),
    .full(full), .empty(empty), .head(head)
  );
  // Responses are only policed once a post-reset load exists, so stale data is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      err_unexp_rsp <= 1'b0;
      armed <= 1'b0;
    end else begin
      rf_we <= wr;
      if (wr) begin
        rf_waddr <= src.rd;
        rf_wdata <= res[XLEN-1:0];
      end
      armed <= armed | (push & is_load(op_in));
      err_unexp_rsp <= err_unexp_rsp | (mem_rvalid & armed & (empty | !is_load(head.op)));
    end
  end
  logic unused_imm;
  assign unused_imm = ^{src.imm[XLEN_MAX-1:32], src.imm[11:0]};
  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^res[XLEN_MAX-1:XLEN];
  end
endmodule

// File: tb/tb_wb_retire_queue.sv
// tb_wb_retire_queue: directed timing checks plus randomized traffic against a queue-level model.
`timescale 1ns/1ps
module tb_wb_retire_queue;
  import cu_pkg::*;
  localparam int XLEN = 32, DEPTH = 4;
  logic clk = 0, rst = 1, in_valid = 0, mem_rvalid = 0;
  logic [5:0] in_op = 0;
  logic [4:0] in_rd = 0;
  logic [31:0] in_pc = 0, in_alu = 0, in_imm = 0, mem_rdata = 0;
  logic [1:0] in_addr_lo = 0;
  logic in_ready, rf_we, busy, err_unexp_rsp;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  wb_retire_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_pc(in_pc), .in_alu(in_alu), .in_imm(in_imm), .in_addr_lo(in_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .busy(busy), .err_unexp_rsp(err_unexp_rsp)
  );

  typedef struct { cuOPType op; logic [4:0] rd; logic [31:0] pc, alu, imm; logic [1:0] lo; } ent_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;
  ent_t mq[$];
  wr_t exp_q[$];
  bit armed = 0, m_err = 0, m_we = 0;
  cuOPType ops [17] = '{CU_ADD, CU_ADDI, CU_SUB, CU_LUI, CU_AUIPC, CU_JAL, CU_JALR, CU_BEQ, CU_BNE,
                        CU_SW, CU_SB, CU_ERROR, CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU};

  function automatic bit tb_load(cuOPType op);
    return op inside {CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU};
  endfunction
  function automatic bit tb_writes(cuOPType op);
    return !(op inside {CU_ERROR, CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
                        CU_SB, CU_SH, CU_SW, CU_SD});
  endfunction
  function automatic logic [31:0] tb_result(ent_t e, logic [31:0] rdata);
    logic [63:0] sh, w;
    sh = 64'(rdata >> (8 * e.lo));
    case (e.op)
      CU_LB:   w = (sh % 256 >= 128) ? sh % 256 - 256 : sh % 256;
      CU_LBU:  w = sh % 256;
      CU_LH:   w = (sh % 65536 >= 32768) ? sh % 65536 - 65536 : sh % 65536;
      CU_LHU:  w = sh % 65536;
      CU_LW:   w = sh;
      CU_LUI:  w = 64'(e.imm / 4096 * 4096);
      CU_AUIPC: w = 64'(e.pc + e.imm / 4096 * 4096);
      CU_JAL, CU_JALR: w = 64'(e.pc + 4);
      default: w = 64'(e.alu);
    endcase
    return w[31:0];
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: whole entries move through a queue following the retire rules.
  always @(posedge clk) begin : model
    ent_t e;
    int n;
    bit bypass;
    m_we = 0;
    if (rst) begin
      mq.delete();
      armed = 0;
      m_err = 0;
    end else begin
      n = mq.size();
      if (mem_rvalid && armed && (n == 0 || !tb_load(mq[0].op))) m_err = 1;
      if (n > 0 && (!tb_load(mq[0].op) || mem_rvalid)) begin
        e = mq.pop_front();
        if (tb_writes(e.op) && e.rd != 0) begin
          exp_q.push_back('{rd: e.rd, data: tb_result(e, mem_rdata)});
          m_we = 1;
        end
      end
      if (in_valid && n < DEPTH) begin
        e = '{op: cuOPType'(in_op), rd: in_rd, pc: in_pc, alu: in_alu, imm: in_imm, lo: in_addr_lo};
        bypass = 0;
`ifdef WB_BYPASS_EN
        bypass = n == 0 && !tb_load(e.op);
`endif
        if (bypass) begin
          if (tb_writes(e.op) && e.rd != 0) begin
            exp_q.push_back('{rd: e.rd, data: tb_result(e, mem_rdata)});
            m_we = 1;
          end
        end else mq.push_back(e);
        if (tb_load(e.op)) armed = 1;
      end
    end
  end

  always @(negedge clk) begin : monitor
    wr_t w;
    check("mon_rf_we", rf_we, m_we);
    check("mon_in_ready", in_ready, mq.size() < DEPTH);
    check("mon_busy", busy, mq.size() > 0 || m_we);
    check("mon_err", err_unexp_rsp, m_err);
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected_write: got rd %0d data %h expected no write", rf_waddr, rf_wdata);
      end else begin
        w = exp_q.pop_front();
        check("mon_waddr", rf_waddr, w.rd);
        check("mon_wdata", rf_wdata, w.data);
      end
    end
  end

  task automatic drive(cuOPType op, logic [4:0] rd, logic [31:0] pc, logic [31:0] alu,
                       logic [31:0] imm, logic [1:0] lo);
    in_valid = 1; in_op = op; in_rd = rd; in_pc = pc; in_alu = alu; in_imm = imm; in_addr_lo = lo;
  endtask

  task automatic op_test(string nm, cuOPType op, logic [4:0] rd, logic [31:0] pc, logic [31:0] alu,
                         logic [31:0] imm, bit we, logic [31:0] d);
    drive(op, rd, pc, alu, imm, 0);
    @(negedge clk);
    in_valid = 0;
`ifndef WB_BYPASS_EN
    check({nm, "_early"}, rf_we, 0);
    @(negedge clk);
`endif
    check({nm, "_we"}, rf_we, we);
    if (we) begin
      check({nm, "_waddr"}, rf_waddr, rd);
      check({nm, "_wdata"}, rf_wdata, d);
    end
    @(negedge clk);
    check({nm, "_once"}, rf_we, 0);
  endtask

  task automatic ld_test(string nm, cuOPType op, logic [4:0] rd, logic [1:0] lo, logic [31:0] rdata,
                         logic [31:0] d);
    drive(op, rd, 0, 0, 0, lo);
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check({nm, "_stall"}, rf_we, 0);
    mem_rvalid = 1;
    mem_rdata = rdata;
    @(negedge clk);
    mem_rvalid = 0;
    check({nm, "_we"}, rf_we, 1);
    check({nm, "_waddr"}, rf_waddr, rd);
    check({nm, "_wdata"}, rf_wdata, d);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_err", err_unexp_rsp, 0);
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);

    op_test("addi", CU_ADDI, 5, 0, 32'h11, 0, 1, 32'h11);
    ld_test("lb", CU_LB, 3, 2, 32'h0080_0000, 32'hFFFF_FF80);
    ld_test("lbu", CU_LBU, 3, 2, 32'h0080_0000, 32'h0000_0080);
    ld_test("lh", CU_LH, 1, 0, 32'h0000_8001, 32'hFFFF_8001);
    ld_test("lhu", CU_LHU, 1, 0, 32'h0000_8001, 32'h0000_8001);

    drive(CU_LW, 4, 0, 0, 0, 0);
    @(negedge clk);
    drive(CU_ADDI, 2, 0, 32'h22, 0, 0);
    @(negedge clk);
    drive(CU_ADDI, 6, 0, 32'h66, 0, 0);
    @(negedge clk);
    drive(CU_ADD, 7, 0, 32'h77, 0, 0);
    @(negedge clk);
    check("fill_ready", in_ready, 0);
    drive(CU_ADDI, 9, 0, 32'h99, 0, 0);
    @(negedge clk);
    in_valid = 0;
    check("fill_ready_hold", in_ready, 0);
    check("fill_stall", rf_we, 0);
    mem_rvalid = 1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 0;
    check("fill_ld_waddr", rf_waddr, 4);
    check("fill_ld_wdata", rf_wdata, 32'h1234_5678);
    @(negedge clk);
    check("fill_addi_waddr", rf_waddr, 2);
    check("fill_addi_wdata", rf_wdata, 32'h22);
    @(negedge clk);
    check("fill_3_waddr", rf_waddr, 6);
    @(negedge clk);
    check("fill_4_waddr", rf_waddr, 7);
    @(negedge clk);
    check("fill_drop", rf_we, 0);

    op_test("auipc", CU_AUIPC, 8, 32'h100, 0, 32'h0000_2000, 1, 32'h2100);
    op_test("lui", CU_LUI, 10, 0, 0, 32'h8000_1ABC, 1, 32'h8000_1000);
    op_test("jal", CU_JAL, 1, 32'h40, 0, 0, 1, 32'h44);
    op_test("sw", CU_SW, 7, 0, 32'h55, 0, 0, 0);
    op_test("rd0", CU_ADDI, 0, 0, 32'h55, 0, 0, 0);

    mem_rvalid = 1;
    @(negedge clk);
    mem_rvalid = 0;
    check("unexp_err", err_unexp_rsp, 1);
    repeat (3) @(negedge clk);
    check("unexp_sticky", err_unexp_rsp, 1);

    drive(CU_LB, 3, 0, 0, 0, 1);
    @(negedge clk);
    in_valid = 0;
    check("mid_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err_unexp_rsp, 0);
    mem_rvalid = 1;
    mem_rdata = 32'hFF;
    @(negedge clk);
    mem_rvalid = 0;
    check("stale_no_write", rf_we, 0);
    @(negedge clk);
    check("stale_no_err", err_unexp_rsp, 0);

    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 299) == 0;
      if (!rst && $urandom_range(0, 99) < 60)
        drive(ops[$urandom_range(0, 16)], 5'($urandom), $urandom, $urandom, $urandom, 2'($urandom));
      else in_valid = 0;
      mem_rvalid = (mq.size() > 0 && tb_load(mq[0].op)) ? $urandom_range(0, 99) < 40
                                                         : $urandom_range(0, 99) < 2;
      mem_rdata = $urandom;
      @(negedge clk);
    end
    rst = 0;
    in_valid = 0;
    for (int c = 0; c < 100 && (mq.size() > 0 || exp_q.size() > 0); c++) begin
      mem_rvalid = mq.size() > 0 && tb_load(mq[0].op);
      mem_rdata = $urandom;
      @(negedge clk);
    end
    mem_rvalid = 0;
    @(negedge clk);
    check("drain_busy", busy, 0);
    check("drain_pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
